// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router port control slice.
package router_pkg;

  localparam int NUM_PORTS       = 3;
  localparam int TIMEOUT_DEFAULT = 30;

  typedef logic [1:0] port_addr_t;

  localparam port_addr_t ADDR_NONE = 2'b11;

endpackage

// File: rtl/router_port_timer.sv
// Per-port unread-data timeout. Counts cycles where the port has data and is
// not being read; on the TIMEOUT-th such cycle it registers a one-cycle
// soft_reset pulse and restarts from zero. A read or an empty FIFO clears it.
// Only built when ROUTER_PORT_TIMEOUT_EN is defined.
`ifdef ROUTER_PORT_TIMEOUT_EN
module router_port_timer
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);

  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          soft_reset_q, soft_reset_d;

  // Next-state: a read takes priority over reaching the terminal count.
  always_comb begin
    cnt_d        = cnt_q;
    soft_reset_d = 1'b0;
    if (rd || !vld) begin
      cnt_d = '0;
    end else if (cnt_q == TERM) begin
      cnt_d        = '0;
      soft_reset_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter and pulse registers; async reset drops any count in flight.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q        <= '0;
      soft_reset_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      soft_reset_q <= soft_reset_d;
    end
  end

  assign soft_reset = soft_reset_q;

endmodule
`endif

// File: rtl/router_port_ctrl.sv
// Port control between the router FSM and the three output FIFOs: latches the
// header address, steers the write strobe one-hot, returns the addressed full
// flag, drives valid-out, and (with ROUTER_PORT_TIMEOUT_EN) times out unread
// ports with a one-cycle soft reset. Without the macro soft_reset_* are 0.
module router_port_ctrl
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
);

  port_addr_t addr_q, addr_d;

  // Address latch next-state: load on header decode, otherwise hold.
  always_comb begin
    addr_d = addr_q;
    if (detect_add) addr_d = data_in;
  end

  // Address register; soft resets deliberately do not touch it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) addr_q <= ADDR_NONE;
    else         addr_q <= addr_d;
  end

  // One-hot write steering; an invalid address suppresses all writes.
  always_comb begin
    write_enb = 3'b000;
    if (write_enb_reg) begin
      case (addr_q)
        2'd0:    write_enb = 3'b001;
        2'd1:    write_enb = 3'b010;
        2'd2:    write_enb = 3'b100;
        default: write_enb = 3'b000;
      endcase
    end
  end

  // Full flag of the addressed FIFO back to the FSM.
  always_comb begin
    case (addr_q)
      2'd0:    fifo_full = full_0;
      2'd1:    fifo_full = full_1;
      2'd2:    fifo_full = full_2;
      default: fifo_full = 1'b0;
    endcase
  end

  assign vld_out_0 = ~empty_0;
  assign vld_out_1 = ~empty_1;
  assign vld_out_2 = ~empty_2;

`ifdef ROUTER_PORT_TIMEOUT_EN
  logic [NUM_PORTS-1:0] vld_v, rd_v, soft_reset_v;

  assign vld_v = {vld_out_2, vld_out_1, vld_out_0};
  assign rd_v  = {read_enb_2, read_enb_1, read_enb_0};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_timer
    router_port_timer #(
      .TIMEOUT (TIMEOUT)
    ) u_timer (
      .clock      (clock),
      .resetn     (resetn),
      .vld        (vld_v[p]),
      .rd         (rd_v[p]),
      .soft_reset (soft_reset_v[p])
    );
  end

  assign soft_reset_0 = soft_reset_v[0];
  assign soft_reset_1 = soft_reset_v[1];
  assign soft_reset_2 = soft_reset_v[2];
`else
  // Read enables only feed the timers, so they are intentionally unused here.
  logic unused_rd;
  assign unused_rd    = ^{read_enb_0, read_enb_1, read_enb_2};
  assign soft_reset_0 = 1'b0;
  assign soft_reset_1 = 1'b0;
  assign soft_reset_2 = 1'b0;
`endif

endmodule

// File: tb/tb_router_port_ctrl.sv
// Directed bench for router_port_ctrl. Soft-reset expectations depend on
// whether ROUTER_PORT_TIMEOUT_EN is defined for the build.
module tb_router_port_ctrl;

  localparam int TO = 30;
`ifdef ROUTER_PORT_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       resetn;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       empty_0, empty_1, empty_2;
  logic       full_0, full_1, full_2;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;

  int checks = 0;
  int errors = 0;

  router_port_ctrl #(.TIMEOUT(TO)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .detect_add    (detect_add),
    .data_in       (data_in),
    .write_enb_reg (write_enb_reg),
    .read_enb_0    (read_enb_0),
    .read_enb_1    (read_enb_1),
    .read_enb_2    (read_enb_2),
    .empty_0       (empty_0),
    .empty_1       (empty_1),
    .empty_2       (empty_2),
    .full_0        (full_0),
    .full_1        (full_1),
    .full_2        (full_2),
    .write_enb     (write_enb),
    .fifo_full     (fifo_full),
    .vld_out_0     (vld_out_0),
    .vld_out_1     (vld_out_1),
    .vld_out_2     (vld_out_2),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    detect_add = 1'b1; data_in = 2'd0;
    tick();
    detect_add = 1'b0; write_enb_reg = 1'b1; full_0 = 1'b1; empty_1 = 1'b0;
    #1;
    checks++;
    if (write_enb !== 3'b001) begin errors++; $display("FAIL pre_reset_we got %b exp 001", write_enb); end
    checks++;
    if (fifo_full !== 1'b1) begin errors++; $display("FAIL pre_reset_full got %b exp 1", fifo_full); end
    repeat (10) tick();
    resetn = 1'b0;
    #1;
    checks++;
    if (write_enb !== 3'b000) begin errors++; $display("FAIL rst_we got %b exp 000", write_enb); end
    checks++;
    if (fifo_full !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", fifo_full); end
    checks++;
    if ({soft_reset_2, soft_reset_1, soft_reset_0} !== 3'b000) begin
      errors++; $display("FAIL rst_sr got %b exp 000", {soft_reset_2, soft_reset_1, soft_reset_0});
    end
    checks++;
    if (vld_out_1 !== 1'b1) begin errors++; $display("FAIL rst_vld1 got %b exp 1", vld_out_1); end
    repeat (2) tick();
    resetn = 1'b1;
    #1;
    checks++;
    if (write_enb !== 3'b000) begin errors++; $display("FAIL post_rst_we got %b exp 000", write_enb); end
    // Counter restarts from 0 after release: pulse on the TO-th edge.
    for (int i = 1; i <= TO + 1; i++) begin
      tick();
      checks++;
      if ({soft_reset_2, soft_reset_1, soft_reset_0} !== {1'b0, (TEN && i == TO), 1'b0}) begin
        errors++;
        $display("FAIL rst_restart edge %0d got %b exp %b", i,
                 {soft_reset_2, soft_reset_1, soft_reset_0}, {1'b0, (TEN && i == TO), 1'b0});
      end
    end
    empty_1 = 1'b1; write_enb_reg = 1'b0; full_0 = 1'b0;
    tick();
  endtask

  task automatic test_steering;
    detect_add = 1'b1; data_in = 2'd2; write_enb_reg = 1'b1;
    #1;
    checks++;
    if (write_enb !== 3'b000) begin errors++; $display("FAIL steer_latency got %b exp 000", write_enb); end
    tick();
    detect_add = 1'b0;
    #1;
    checks++;
    if (write_enb !== 3'b100) begin errors++; $display("FAIL steer_p2 got %b exp 100", write_enb); end
    full_2 = 1'b1; full_0 = 1'b0;
    #1;
    checks++;
    if (fifo_full !== 1'b1) begin errors++; $display("FAIL full_p2 got %b exp 1", fifo_full); end
    write_enb_reg = 1'b0;
    #1;
    checks++;
    if (write_enb !== 3'b000) begin errors++; $display("FAIL steer_idle got %b exp 000", write_enb); end
    detect_add = 1'b1; data_in = 2'd1;
    tick();
    detect_add = 1'b0; write_enb_reg = 1'b1; full_1 = 1'b0;
    #1;
    checks++;
    if (write_enb !== 3'b010) begin errors++; $display("FAIL steer_p1 got %b exp 010", write_enb); end
    checks++;
    if (fifo_full !== 1'b0) begin errors++; $display("FAIL full_p1 got %b exp 0", fifo_full); end
    detect_add = 1'b1; data_in = 2'd3; full_0 = 1'b1; full_1 = 1'b1;
    tick();
    detect_add = 1'b0;
    #1;
    checks++;
    if (write_enb !== 3'b000) begin errors++; $display("FAIL steer_inv got %b exp 000", write_enb); end
    checks++;
    if (fifo_full !== 1'b0) begin errors++; $display("FAIL full_inv got %b exp 0", fifo_full); end
    empty_0 = 1'b0; empty_1 = 1'b1; empty_2 = 1'b0;
    #1;
    checks++;
    if ({vld_out_2, vld_out_1, vld_out_0} !== 3'b101) begin
      errors++; $display("FAIL vld_pattern got %b exp 101", {vld_out_2, vld_out_1, vld_out_0});
    end
    empty_0 = 1'b1; empty_2 = 1'b1; write_enb_reg = 1'b0;
    full_0 = 1'b0; full_1 = 1'b0; full_2 = 1'b0;
    tick();
  endtask

  task automatic test_timeout;
    empty_1 = 1'b0;
    for (int i = 1; i <= TO + 1; i++) begin
      tick();
      checks++;
      if ({soft_reset_2, soft_reset_1, soft_reset_0} !== {1'b0, (TEN && i == TO), 1'b0}) begin
        errors++;
        $display("FAIL timeout edge %0d got %b exp %b", i,
                 {soft_reset_2, soft_reset_1, soft_reset_0}, {1'b0, (TEN && i == TO), 1'b0});
      end
    end
    empty_1 = 1'b1;
    tick();
  endtask

  task automatic test_read_rescue;
    // Read on the terminal edge: no pulse, then a full new window.
    empty_1 = 1'b0;
    for (int i = 1; i <= 2 * TO + 1; i++) begin
      read_enb_1 = (i == TO);
      tick();
      checks++;
      if (soft_reset_1 !== (TEN && i == 2 * TO)) begin
        errors++;
        $display("FAIL rescue30 edge %0d got %b exp %b", i, soft_reset_1, (TEN && i == 2 * TO));
      end
    end
    read_enb_1 = 1'b0; empty_1 = 1'b1;
    tick();
    // Read on edge 20: pulse moves to the TO-th edge after the read.
    empty_1 = 1'b0;
    for (int i = 1; i <= 20 + TO + 1; i++) begin
      read_enb_1 = (i == 20);
      tick();
      checks++;
      if (soft_reset_1 !== (TEN && i == 20 + TO)) begin
        errors++;
        $display("FAIL rescue20 edge %0d got %b exp %b", i, soft_reset_1, (TEN && i == 20 + TO));
      end
    end
    read_enb_1 = 1'b0; empty_1 = 1'b1;
    tick();
  endtask

  task automatic test_simultaneous;
    empty_0 = 1'b0; empty_2 = 1'b0;
    for (int i = 1; i <= TO + 1; i++) begin
      tick();
      checks++;
      if ({soft_reset_2, soft_reset_1, soft_reset_0} !==
          {(TEN && i == TO), 1'b0, (TEN && i == TO)}) begin
        errors++;
        $display("FAIL simul edge %0d got %b exp %b", i, {soft_reset_2, soft_reset_1, soft_reset_0},
                 {(TEN && i == TO), 1'b0, (TEN && i == TO)});
      end
    end
    empty_0 = 1'b1; empty_2 = 1'b1;
    tick();
  endtask

`ifndef ROUTER_PORT_TIMEOUT_EN
  task automatic test_macro_off;
    empty_0 = 1'b0; empty_1 = 1'b0; empty_2 = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      checks++;
      if ({soft_reset_2, soft_reset_1, soft_reset_0} !== 3'b000) begin
        errors++;
        $display("FAIL macro_off edge %0d got %b exp 000", i, {soft_reset_2, soft_reset_1, soft_reset_0});
      end
    end
    empty_0 = 1'b1; empty_1 = 1'b1; empty_2 = 1'b1;
    tick();
  endtask
`endif

  initial begin
    resetn = 1'b0; detect_add = 1'b0; data_in = 2'd0; write_enb_reg = 1'b0;
    read_enb_0 = 1'b0; read_enb_1 = 1'b0; read_enb_2 = 1'b0;
    empty_0 = 1'b1; empty_1 = 1'b1; empty_2 = 1'b1;
    full_0 = 1'b0; full_1 = 1'b0; full_2 = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    test_reset();
    test_steering();
    test_timeout();
    test_read_rescue();
    test_simultaneous();
`ifndef ROUTER_PORT_TIMEOUT_EN
    test_macro_off();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
